// File: rtl/lc3b_pipeline_ctrl.sv
// lc3b_pipeline_ctrl: stall/flush sequencer for the 5-stage LC-3b pipeline.
// Ports: memory handshakes (imem_resp, dmem_resp, mem_op_valid) and hazard inputs
//   (ID sources, EX load destination, MEM taken branch) in; PC/stage load and
//   flush enables, fetch/data request, FSM state and saturating stall/flush
//   counters out.
// All enables are combinational from the current inputs and state. Only
//   ctrl_state and the counters are registered.
module lc3b_pipeline_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_resp,
  input  logic                 dmem_resp,
  input  logic                 mem_op_valid,
  input  logic                 id_valid,
  input  logic                 id_uses_sr1,
  input  logic                 id_uses_sr2,
  input  logic [2:0]           id_sr1,
  input  logic [2:0]           id_sr2,
  input  logic                 ex_is_load,
  input  logic [2:0]           ex_dest,
  input  logic                 mem_br_taken,
  output logic                 imem_read,
  output logic                 dmem_req,
  output logic                 load_pc,
  output logic                 pc_sel_redirect,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic [1:0]           ctrl_state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_LU_STALL = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_busy;
  logic lu_hazard;

  assign mem_busy  = (mem_op_valid & ~dmem_resp) | ~imem_resp;
  assign lu_hazard = ex_is_load & id_valid &
                     ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                      (id_uses_sr2 & (id_sr2 == ex_dest)));

  always_comb begin
    state_d         = state_q;
    imem_read       = 1'b0;
    dmem_req        = 1'b0;
    load_pc         = 1'b0;
    pc_sel_redirect = 1'b0;
    load_if_id      = 1'b0;
    load_id_ex      = 1'b0;
    load_ex_mem     = 1'b0;
    load_mem_wb     = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    flush_ex_mem    = 1'b0;

    if (state_q == ST_INIT) begin
      // Clear every stage register with a bubble; PC and fetch stay idle.
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      state_d      = ST_RUN;
    end else begin
      imem_read = 1'b1;
      dmem_req  = mem_op_valid;
      if (mem_busy) begin
        // Freeze everything until both memories answer.
        state_d = ST_MEM_WAIT;
      end else if (mem_br_taken) begin
        // Redirect squashes IF/ID/EX, including any load-use victim in ID.
        load_pc         = 1'b1;
        load_if_id      = 1'b1;
        load_id_ex      = 1'b1;
        load_ex_mem     = 1'b1;
        load_mem_wb     = 1'b1;
        flush_if_id     = 1'b1;
        flush_id_ex     = 1'b1;
        flush_ex_mem    = 1'b1;
        pc_sel_redirect = 1'b1;
        state_d         = ST_RUN;
      end else if (lu_hazard) begin
        // Hold PC and IF/ID, push one bubble into EX behind the load.
        load_id_ex  = 1'b1;
        flush_id_ex = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        state_d     = ST_LU_STALL;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        state_d     = ST_RUN;
      end
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != ST_INIT) && !load_pc && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if ((state_q != ST_INIT) && pc_sel_redirect && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;

    // Reset drops every enable and request immediately.
    if (reset) begin
      imem_read       = 1'b0;
      dmem_req        = 1'b0;
      load_pc         = 1'b0;
      pc_sel_redirect = 1'b0;
      load_if_id      = 1'b0;
      load_id_ex      = 1'b0;
      load_ex_mem     = 1'b0;
      load_mem_wb     = 1'b0;
      flush_if_id     = 1'b0;
      flush_id_ex     = 1'b0;
      flush_ex_mem    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_lc3b_pipeline_ctrl.sv
// Directed bench for lc3b_pipeline_ctrl: vector table plus hand sequences for
// counter saturation and asynchronous reset mid-stall.
module tb_lc3b_pipeline_ctrl;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic imem_resp, dmem_resp, mem_op_valid, id_valid, id_uses_sr1, id_uses_sr2;
  logic [2:0] id_sr1, id_sr2, ex_dest;
  logic ex_is_load, mem_br_taken;
  logic imem_read, dmem_req, load_pc, pc_sel_redirect;
  logic load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] ctrl_state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3b_pipeline_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_resp(imem_resp), .dmem_resp(dmem_resp), .mem_op_valid(mem_op_valid),
    .id_valid(id_valid), .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .mem_br_taken(mem_br_taken),
    .imem_read(imem_read), .dmem_req(dmem_req), .load_pc(load_pc),
    .pc_sel_redirect(pc_sel_redirect),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // io = {imem_read, dmem_req, load_pc, pc_sel_redirect}
  // ld = {load_if_id, load_id_ex, load_ex_mem, load_mem_wb}
  // fl = {flush_if_id, flush_id_ex, flush_ex_mem}
  typedef struct {
    logic       imem, dmem, mop, idv, us1, us2;
    logic [2:0] sr1, sr2;
    logic       exl;
    logic [2:0] exd;
    logic       br;
    logic [1:0] st;
    logic [3:0] io;
    logic [3:0] ld;
    logic [2:0] fl;
    int         scnt, fcnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imem_resp    = v.imem;  dmem_resp   = v.dmem;  mem_op_valid = v.mop;
    id_valid     = v.idv;   id_uses_sr1 = v.us1;   id_uses_sr2  = v.us2;
    id_sr1       = v.sr1;   id_sr2      = v.sr2;   ex_is_load   = v.exl;
    ex_dest      = v.exd;   mem_br_taken = v.br;
  endtask

  task automatic idle();
    imem_resp = 1'b1; dmem_resp = 1'b0; mem_op_valid = 1'b0; id_valid = 1'b0;
    id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0; id_sr1 = 3'd0; id_sr2 = 3'd0;
    ex_is_load = 1'b0; ex_dest = 3'd0; mem_br_taken = 1'b0;
  endtask

  initial begin
    //            imem dmem mop idv us1 us2 sr1 sr2 exl exd br  st  io       ld       fl      scnt fcnt
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd0,4'b0000,4'b1111,3'b111, 0, 0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd1,4'b1010,4'b1111,3'b000, 0, 0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd1,4'b1000,4'b0000,3'b000, 0, 0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd2,4'b1000,4'b0000,3'b000, 1, 0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd2,4'b1000,4'b0000,3'b000, 2, 0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd2,4'b1010,4'b1111,3'b000, 3, 0};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd1,4'b1100,4'b0000,3'b000, 3, 0};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd2,4'b1100,4'b0000,3'b000, 4, 0};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd2,4'b1110,4'b1111,3'b000, 5, 0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,3'd3,1'b0, 2'd1,4'b1000,4'b0111,3'b010, 5, 0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd0,1'b0,3'd3,1'b0, 2'd3,4'b1010,4'b1111,3'b000, 6, 0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,3'd0,3'd5,1'b1,3'd5,1'b0, 2'd1,4'b1000,4'b0111,3'b010, 6, 0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd2,3'd0,1'b1,3'd3,1'b0, 2'd3,4'b1010,4'b1111,3'b000, 7, 0};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,3'd3,3'd0,1'b1,3'd3,1'b0, 2'd1,4'b1010,4'b1111,3'b000, 7, 0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,3'd3,1'b1, 2'd1,4'b1011,4'b1111,3'b111, 7, 0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd1,4'b1010,4'b1111,3'b000, 7, 1};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,3'd3,1'b0, 2'd1,4'b1000,4'b0111,3'b010, 7, 1};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd3,4'b1000,4'b0000,3'b000, 8, 1};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd2,4'b1010,4'b1111,3'b000, 9, 1};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b1, 2'd1,4'b1000,4'b0000,3'b000, 9, 1};
    vecs[20] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b1, 2'd2,4'b1011,4'b1111,3'b111, 10, 1};
    vecs[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0, 2'd1,4'b1010,4'b1111,3'b000, 10, 2};

    // Reset phase: everything quiet, counters clear.
    reset = 1'b1;
    idle();
    mem_op_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", -1, int'(ctrl_state), 0);
    chk("rst_io", -1, int'({imem_read, dmem_req, load_pc, pc_sel_redirect}), 0);
    chk("rst_ld", -1, int'({load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 0);
    chk("rst_fl", -1, int'({flush_if_id, flush_id_ex, flush_ex_mem}), 0);
    chk("rst_cnt", -1, int'({stall_cnt, flush_cnt}), 0);

    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk("state", i, int'(ctrl_state), int'(vecs[i].st));
      chk("io", i, int'({imem_read, dmem_req, load_pc, pc_sel_redirect}), int'(vecs[i].io));
      chk("loads", i, int'({load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), int'(vecs[i].ld));
      chk("flushes", i, int'({flush_if_id, flush_id_ex, flush_ex_mem}), int'(vecs[i].fl));
      chk("stall_cnt", i, int'(stall_cnt), vecs[i].scnt);
      chk("flush_cnt", i, int'(flush_cnt), vecs[i].fcnt);
      @(negedge clk);
    end

    // Long fetch stall drives stall_cnt into saturation.
    idle();
    imem_resp = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    chk("stall_sat", 100, int'(stall_cnt), 255);
    chk("stall_sat_state", 100, int'(ctrl_state), 2);
    chk("stall_sat_ld", 100, int'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 0);

    // Back-to-back redirects drive flush_cnt into saturation.
    imem_resp = 1'b1;
    mem_br_taken = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    chk("flush_sat", 101, int'(flush_cnt), 255);
    chk("flush_sat_stall", 101, int'(stall_cnt), 255);
    chk("flush_sat_redir", 101, int'(pc_sel_redirect), 1);

    // Reset mid-stall, between clock edges: state and counters clear at once.
    idle();
    imem_resp = 1'b0;
    mem_op_valid = 1'b1;
    @(posedge clk);
    #3;
    chk("pre_rst_state", 102, int'(ctrl_state), 2);
    reset = 1'b1;
    #1;
    chk("arst_state", 102, int'(ctrl_state), 0);
    chk("arst_cnt", 102, int'({stall_cnt, flush_cnt}), 0);
    chk("arst_req", 102, int'({imem_read, dmem_req}), 0);
    chk("arst_ld_fl", 102, int'({load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                               flush_if_id, flush_id_ex, flush_ex_mem}), 0);

    @(negedge clk);
    reset = 1'b0;
    imem_resp = 1'b1;
    mem_op_valid = 1'b0;
    #1;
    chk("reinit_state", 103, int'(ctrl_state), 0);
    chk("reinit_ld_fl", 103, int'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                                 flush_if_id, flush_id_ex, flush_ex_mem}), 8'b0111_1111);
    chk("reinit_imem", 103, int'(imem_read), 0);
    @(negedge clk);
    #1;
    chk("rerun_state", 104, int'(ctrl_state), 1);
    chk("rerun_io", 104, int'({imem_read, load_pc}), 2'b11);
    chk("rerun_cnt", 104, int'({stall_cnt, flush_cnt}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
